dzcpu_trace_buffer: RTL and testbench

DZCPU_TRACE_BUFFER -- requirements
Module: dzcpu_trace_buffer

---
 rtl/dzcpu_trace_buffer.sv | 175 +++++++++++++++++
 tb/tb_dzcpu_trace_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dzcpu_trace_buffer.sv
// dzcpu_trace_buffer -- circular trace capture buffer for DZCPU.
// Samples {PC, opcode} into a ring while armed. A qualified trigger starts a
// post-trigger countdown. Once DONE, entries are read out oldest-first, one
// per request, with one cycle of read latency.
// Optional feature macro: DZCPU_TRACE_TIMESTAMP_EN prepends a free-running
// 16-bit cycle stamp to every stored entry.
module dzcpu_trace_buffer #(
    parameter int DATA_WIDTH   = 24,
    parameter int DEPTH        = 64,
    parameter int POST_TRIGGER = 16
) (
    input  logic                          iClock,
    input  logic                          iReset_n,
    input  logic                          iArm,
    input  logic                          iValid,
    input  logic [DATA_WIDTH-1:0]         iData,
    input  logic                          iTrigger,
    input  logic                          iRdReq,
`ifdef DZCPU_TRACE_TIMESTAMP_EN
    output logic [DATA_WIDTH+15:0]        oRdData,
`else
    output logic [DATA_WIDTH-1:0]         oRdData,
`endif
    output logic                          oRdValid,
    output logic [1:0]                    oState,
    output logic [$clog2(DEPTH):0]        oCount,
    output logic                          oDone
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef DZCPU_TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = DATA_WIDTH + 16;
`else
    localparam int ENTRY_W = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [AW-1:0]        post_q, post_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [ENTRY_W-1:0]   rd_data_q;
    logic [ENTRY_W-1:0]   wr_entry;
    logic                 wr_en;
    logic                 rd_fire;

    logic [ENTRY_W-1:0]   mem [DEPTH];

`ifdef DZCPU_TRACE_TIMESTAMP_EN
    logic [15:0]          ts_q, ts_d;

    // Free-running cycle stamp; wraps naturally at 16 bits.
    always_comb begin
        ts_d = ts_q + 16'd1;
    end

    // Cycle stamp register.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) ts_q <= '0;
        else           ts_q <= ts_d;
    end

    assign wr_entry = {ts_q, iData};
`else
    assign wr_entry = iData;
`endif

    // Capture/readout sequencing: next state, pointers, count and post counter.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch behind.
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        post_d     = post_q;
        wr_en      = 1'b0;
        rd_fire    = (state_q == S_DONE) && (count_q != '0) && iRdReq;
        rd_valid_d = rd_fire;

        unique case (state_q)
            S_IDLE: begin
                if (iArm) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                    state_d  = S_ARMED;
                end
            end
            S_ARMED, S_POST: begin
                if (iValid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (count_q != CW'(DEPTH)) count_d = count_q + 1'b1;
                    if (state_q == S_ARMED) begin
                        if (iTrigger) begin
                            if (POST_TRIGGER == 0) begin
                                state_d = S_DONE;
                            end else begin
                                post_d  = AW'(POST_TRIGGER);
                                state_d = S_POST;
                            end
                        end
                    end else begin
                        post_d = post_q - 1'b1;
                        if (post_q == AW'(1)) state_d = S_DONE;
                    end
                    // Oldest surviving sample sits count entries behind the write pointer.
                    if (state_d == S_DONE) rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
                end
            end
            S_DONE: begin
                if (rd_fire) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                end
                // Re-arming drops everything; a read issued this cycle still completes.
                if (iArm) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                    state_d  = S_ARMED;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge iClock or negedge iReset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!iReset_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_q     <= post_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Sample storage write port.
    always_ff @(posedge iClock) begin
        // NOTE: the array has no reset so it maps onto a plain synchronous RAM; stale contents are never read.
        if (wr_en) mem[wr_ptr_q] <= wr_entry;
    end

    // Registered read port; holds the last delivered entry between reads.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n)    rd_data_q <= '0;
        else if (rd_fire) rd_data_q <= mem[rd_ptr_q];
    end

    assign oRdData  = rd_data_q;
    assign oRdValid = rd_valid_q;
    assign oState   = state_q;
    assign oCount   = count_q;
    assign oDone    = (state_q == S_DONE);

endmodule

// File: tb/tb_dzcpu_trace_buffer.sv
// tb_dzcpu_trace_buffer -- directed and randomized checks of the trace buffer
// against a queue-based reference model (DEPTH=8, POST_TRIGGER=2).
module tb_dzcpu_trace_buffer;

    localparam int DW    = 24;
    localparam int DEPTH = 8;
    localparam int PT    = 2;
`ifdef DZCPU_TRACE_TIMESTAMP_EN
    localparam int OW = DW + 16;
`else
    localparam int OW = DW;
`endif

    logic          iClock;
    logic          iReset_n;
    logic          iArm;
    logic          iValid;
    logic [DW-1:0] iData;
    logic          iTrigger;
    logic          iRdReq;
    logic [OW-1:0] oRdData;
    logic          oRdValid;
    logic [1:0]    oState;
    logic [3:0]    oCount;
    logic          oDone;

    dzcpu_trace_buffer #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .POST_TRIGGER(PT)
    ) dut (
        .iClock  (iClock),
        .iReset_n(iReset_n),
        .iArm    (iArm),
        .iValid  (iValid),
        .iData   (iData),
        .iTrigger(iTrigger),
        .iRdReq  (iRdReq),
        .oRdData (oRdData),
        .oRdValid(oRdValid),
        .oState  (oState),
        .oCount  (oCount),
        .oDone   (oDone)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is simply "the last DEPTH samples captured since arm".
    logic [OW-1:0] m_q[$];
    int            m_st    = 0;
    int            m_post  = 0;
    bit            m_rv    = 1'b0;
    logic [OW-1:0] m_rdata = '0;
    logic [15:0]   m_ts    = '0;
    logic [OW-1:0] m_ent;

    always @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            m_st = 0; m_post = 0; m_rv = 1'b0; m_rdata = '0; m_ts = '0;
            m_q.delete();
        end else begin
`ifdef DZCPU_TRACE_TIMESTAMP_EN
            m_ent = {m_ts, iData};
`else
            m_ent = iData;
`endif
            m_rv = (m_st == 3) && (m_q.size() > 0) && iRdReq;
            if (m_rv) m_rdata = m_q.pop_front();
            case (m_st)
                0, 3: if (iArm) begin m_q.delete(); m_st = 1; end
                default: if (iValid) begin
                    m_q.push_back(m_ent);
                    if (m_q.size() > DEPTH) void'(m_q.pop_front());
                    if (m_st == 1) begin
                        if (iTrigger) begin
                            if (PT == 0) m_st = 3;
                            else begin m_post = PT; m_st = 2; end
                        end
                    end else begin
                        m_post--;
                        if (m_post == 0) m_st = 3;
                    end
                end
            endcase
            m_ts = m_ts + 16'd1;
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge iClock) begin
        if (chk_en) begin
            check("state",   64'(oState),   64'(m_st));
            check("count",   64'(oCount),   64'(m_q.size()));
            check("done",    64'(oDone),    64'(m_st == 3));
            check("rdvalid", 64'(oRdValid), 64'(m_rv));
            check("rddata",  64'(oRdData),  64'(m_rdata));
        end
    end

    task automatic cyc();
        @(posedge iClock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic arm();
        iArm = 1'b1; cyc(); iArm = 1'b0;
    endtask

    task automatic send(input int d, input bit trig);
        iValid = 1'b1; iData = DW'(d); iTrigger = trig;
        cyc();
        iValid = 1'b0; iTrigger = 1'b0;
    endtask

    task automatic rd_expect(input string name, input int d);
        iRdReq = 1'b1;
        cyc();
        iRdReq = 1'b0;
        check({name, "_v"}, 64'(oRdValid), 64'd1);
        check({name, "_d"}, 64'(oRdData[DW-1:0]), 64'(d));
    endtask

    task automatic pulse_reset();
        iArm = 1'b0; iValid = 1'b0; iTrigger = 1'b0; iRdReq = 1'b0;
        iReset_n = 1'b0;
        cyc();
        iReset_n = 1'b1;
    endtask

    initial begin
        iReset_n = 1'b1; iArm = 1'b0; iValid = 1'b0; iData = '0;
        iTrigger = 1'b0; iRdReq = 1'b0;
        #2 iReset_n = 1'b0;
        chk_en = 1'b1;
        idle(3);
        check("rst_state", 64'(oState), 64'd0);
        check("rst_count", 64'(oCount), 64'd0);
        check("rst_done",  64'(oDone),  64'd0);
        check("rst_rdv",   64'(oRdValid), 64'd0);
        iReset_n = 1'b1;
        cyc();

        // Samples before arm are ignored.
        send(99, 1'b1);
        check("idle_state", 64'(oState), 64'd0);

        // Short capture: trigger on 3, two post samples.
        arm();
        check("arm_state", 64'(oState), 64'd1);
        for (int i = 1; i <= 5; i++) send(i, i == 3);
        check("c5_state", 64'(oState), 64'd3);
        check("c5_count", 64'(oCount), 64'd5);
        for (int i = 1; i <= 5; i++) rd_expect("c5_rd", i);
        check("c5_empty", 64'(oCount), 64'd0);

        // Read with nothing left.
        iRdReq = 1'b1; cyc(); iRdReq = 1'b0;
        check("drained_rdv",   64'(oRdValid), 64'd0);
        check("drained_count", 64'(oCount),   64'd0);
        check("drained_hold",  64'(oRdData[DW-1:0]), 64'd5);

        // Wrapping capture: only the newest DEPTH samples survive.
        arm();
        for (int i = 1; i <= 20; i++) send(i, i == 18);
        check("c20_state", 64'(oState), 64'd3);
        check("c20_count", 64'(oCount), 64'd8);
        for (int i = 13; i <= 20; i++) rd_expect("c20_rd", i);
        check("c20_empty", 64'(oCount), 64'd0);

        // Re-arm with a read already in flight.
        arm();
        for (int i = 1; i <= 8; i++) send(i, i == 6);
        check("c8_count", 64'(oCount), 64'd8);
        for (int i = 1; i <= 3; i++) rd_expect("c8_rd", i);
        iRdReq = 1'b1; cyc(); iRdReq = 1'b0;
        iArm = 1'b1;
        check("inflight_v", 64'(oRdValid), 64'd1);
        check("inflight_d", 64'(oRdData[DW-1:0]), 64'd4);
        cyc(); iArm = 1'b0;
        check("rearm_state", 64'(oState), 64'd1);
        check("rearm_count", 64'(oCount), 64'd0);

        // Asynchronous reset during POST.
        send(1, 1'b0); send(2, 1'b1); send(3, 1'b0);
        check("post_state", 64'(oState), 64'd2);
        #2 iReset_n = 1'b0;
        #1;
        check("arst_state", 64'(oState), 64'd0);
        check("arst_count", 64'(oCount), 64'd0);
        check("arst_done",  64'(oDone),  64'd0);
        #4 iReset_n = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) send(50 + i, 1'b1);
        check("post_rst_state", 64'(oState), 64'd0);
        check("post_rst_count", 64'(oCount), 64'd0);

        // Randomized traffic, checked by the per-cycle comparator.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
            end else begin
                iArm     = ($urandom_range(0, 49) == 0);
                iValid   = ($urandom_range(0, 9) < 6);
                iTrigger = ($urandom_range(0, 11) == 0);
                iRdReq   = ($urandom_range(0, 9) < 6);
                iData    = DW'($urandom);
                cyc();
            end
        end
        iArm = 1'b0; iValid = 1'b0; iTrigger = 1'b0; iRdReq = 1'b0;

`ifdef DZCPU_TRACE_TIMESTAMP_EN
        begin
            logic [15:0] ts_r [3];
            int          n;
            pulse_reset();
            n = 0;
            while (m_ts != 16'hFFFC && n < 70000) begin cyc(); n++; end
            check("ts_wait_bound", 64'(n < 70000), 64'd1);
            arm();
            idle(2); send(1, 1'b1);
            idle(2); send(2, 1'b0);
            idle(2); send(3, 1'b0);
            check("ts_state", 64'(oState), 64'd3);
            for (int i = 0; i < 3; i++) begin
                iRdReq = 1'b1; cyc(); iRdReq = 1'b0;
                ts_r[i] = oRdData[DW+15:DW];
                check("ts_data", 64'(oRdData[DW-1:0]), 64'(i + 1));
            end
            check("ts0",    64'(ts_r[0]), 64'hFFFF);
            check("ts1",    64'(ts_r[1]), 64'h0002);
            check("ts_d01", 64'(16'(ts_r[1] - ts_r[0])), 64'd3);
            check("ts_d12", 64'(16'(ts_r[2] - ts_r[1])), 64'd3);
        end
`endif

        idle(2);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
